// File: rtl/exception_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | exception_ctrl_pkg                                                   |
// | Shared encodings for the M-stage exception controller: exception     |
// | type codes, CP0 Cause.ExcCode values and the default vector.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package exception_ctrl_pkg;

  // Encoded winning exception as seen by the rest of the pipeline
  localparam logic [31:0] EXC_TYPE_NOEXC = 32'h0000_0000;
  localparam logic [31:0] EXC_TYPE_INT   = 32'h0000_0001;
  localparam logic [31:0] EXC_TYPE_ADEL  = 32'h0000_0004;
  localparam logic [31:0] EXC_TYPE_ADES  = 32'h0000_0005;
  localparam logic [31:0] EXC_TYPE_SYS   = 32'h0000_0008;
  localparam logic [31:0] EXC_TYPE_BP    = 32'h0000_0009;
  localparam logic [31:0] EXC_TYPE_RI    = 32'h0000_000A;
  localparam logic [31:0] EXC_TYPE_OV    = 32'h0000_000C;
  localparam logic [31:0] EXC_TYPE_ERET  = 32'h0000_000E;

  // Cause.ExcCode field values
  localparam logic [4:0] EXCCODE_INT  = 5'h00;
  localparam logic [4:0] EXCCODE_ADEL = 5'h04;
  localparam logic [4:0] EXCCODE_ADES = 5'h05;
  localparam logic [4:0] EXCCODE_SYS  = 5'h08;
  localparam logic [4:0] EXCCODE_BP   = 5'h09;
  localparam logic [4:0] EXCCODE_RI   = 5'h0A;
  localparam logic [4:0] EXCCODE_OV   = 5'h0C;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

  // Status.EXL as a two-state machine
  typedef enum logic [0:0] {
    EXL_NORMAL = 1'b0,
    EXL_EXC    = 1'b1
  } exl_state_e;

  // Map an exception type onto the ExcCode it records
  function automatic logic [4:0] exccode_of(input logic [31:0] exc_type);
    logic [4:0] code;
    code = EXCCODE_INT;
    case (exc_type)
      EXC_TYPE_ADEL: code = EXCCODE_ADEL;
      EXC_TYPE_ADES: code = EXCCODE_ADES;
      EXC_TYPE_SYS:  code = EXCCODE_SYS;
      EXC_TYPE_BP:   code = EXCCODE_BP;
      EXC_TYPE_RI:   code = EXCCODE_RI;
      EXC_TYPE_OV:   code = EXCCODE_OV;
      default:       code = EXCCODE_INT;
    endcase
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/exception_ctrl_int_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | int_sync                                                             |
// | WIDTH-bit, STAGES-deep flop chain bringing asynchronous interrupt    |
// | levels into the clk domain. Synchronous reset clears every stage.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module int_sync #(
  parameter int WIDTH  = 6,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  // Shift the raw levels one stage per clock; reset flushes the chain
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) chain[s] <= '0;
    end else begin
      chain[0] <= d;
      for (int s = 1; s < STAGES; s++) chain[s] <= chain[s-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/exception_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | exception_ctrl                                                       |
// | M-stage exception arbiter and owner of the exception-side CP0 state  |
// | (EXL, EPC, BD, ExcCode, BadVAddr, IP). Drives flush and redirect.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module exception_ctrl
  import exception_ctrl_pkg::*;
#(
  parameter int          HW_INT_N    = 6,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [HW_INT_N-1:0] hw_int,
  input  logic                timer_int,
  input  logic [1:0]          sw_int,
  input  logic                status_ie,
  input  logic [7:0]          status_im,
  input  logic                valid_M,
  input  logic                stall_M,
  input  logic                in_delayslot_M,
  input  logic [31:0]         pc_M,
  input  logic [31:0]         alu_out_M,
  input  logic                ri,
  input  logic                brk,
  input  logic                syscall,
  input  logic                overflow,
  input  logic                eret,
  input  logic                lw_error,
  input  logic                sw_error,
  input  logic                pc_error,
  input  logic                epc_we,
  input  logic [31:0]         epc_wdata,
  output logic [31:0]         exception_type,
  output logic                flush_exception_M,
  output logic [31:0]         pc_exception_M,
  output logic                exl,
  output logic [31:0]         epc,
  output logic                cause_bd,
  output logic [4:0]          cause_exccode,
  output logic [7:0]          cause_ip,
  output logic [31:0]         badvaddr
);

  exl_state_e          state, state_next;
  logic [HW_INT_N-1:0] hw_sync;
  logic [5:0]          hw_ip;
  logic                int_req;
  logic                commit;
  logic                take_exc;

  int_sync #(
    .WIDTH  (HW_INT_N),
    .STAGES (SYNC_STAGES)
  ) u_hw_sync (
    .clk (clk),
    .rst (rst),
    .d   (hw_int),
    .q   (hw_sync)
  );

  // IP[6:2] carry synced lines directly; lines beyond HW_INT_N read 0.
  // IP[7] is shared between the top hardware line and the timer.
  for (genvar i = 0; i < 5; i++) begin : g_hw_ip
    if (i < HW_INT_N) begin : g_used
      assign hw_ip[i] = hw_sync[i];
    end else begin : g_unused
      assign hw_ip[i] = 1'b0;
    end
  end
  assign hw_ip[5]  = hw_sync[HW_INT_N-1] | timer_int;
  assign cause_ip  = {hw_ip, sw_int};

  assign exl     = (state == EXL_EXC);
  assign int_req = status_ie & ~exl & (|(cause_ip & status_im));

  // Fixed-priority selection of the winning exception
  always_comb begin
    exception_type = EXC_TYPE_NOEXC;
    if (int_req)                   exception_type = EXC_TYPE_INT;
    else if (lw_error | pc_error)  exception_type = EXC_TYPE_ADEL;
    else if (ri)                   exception_type = EXC_TYPE_RI;
    else if (syscall)              exception_type = EXC_TYPE_SYS;
    else if (brk)                  exception_type = EXC_TYPE_BP;
    else if (sw_error)             exception_type = EXC_TYPE_ADES;
    else if (overflow)             exception_type = EXC_TYPE_OV;
    else if (eret)                 exception_type = EXC_TYPE_ERET;
  end

  // A stalled or empty M stage holds its exception until it can retire
  assign commit   = valid_M & ~stall_M & (exception_type != EXC_TYPE_NOEXC);
  assign take_exc = commit & (exception_type != EXC_TYPE_ERET);

  // EXL state register
  always_ff @(posedge clk) begin
    if (rst) state <= EXL_NORMAL;
    else     state <= state_next;
  end

  // EXL next state plus flush/redirect; reset forces the redirect idle
  always_comb begin
    state_next        = state;
    flush_exception_M = 1'b0;
    pc_exception_M    = 32'h0;
    if (!rst && commit) begin
      flush_exception_M = 1'b1;
      if (exception_type == EXC_TYPE_ERET) begin
        pc_exception_M = epc;
        state_next     = EXL_NORMAL;
      end else begin
        pc_exception_M = EXC_VECTOR;
        state_next     = EXL_EXC;
      end
    end
  end

  // CP0 exception registers; a committing exception overrides an MTC0 EPC
  always_ff @(posedge clk) begin
    if (rst) begin
      epc           <= 32'h0;
      cause_bd      <= 1'b0;
      cause_exccode <= 5'h0;
      badvaddr      <= 32'h0;
    end else if (take_exc) begin
      // Nested exceptions keep the original return point
      if (state == EXL_NORMAL) begin
        epc      <= in_delayslot_M ? (pc_M - 32'd4) : pc_M;
        cause_bd <= in_delayslot_M;
      end
      cause_exccode <= exccode_of(exception_type);
      if (exception_type == EXC_TYPE_ADEL)
        badvaddr <= pc_error ? pc_M : alu_out_M;
      else if (exception_type == EXC_TYPE_ADES)
        badvaddr <= alu_out_M;
    end else if (epc_we) begin
      epc <= epc_wdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_exception_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_exception_ctrl                                                    |
// | Directed scenarios with literal expectations, then randomized        |
// | traffic checked every cycle against a behavioural CP0 model.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_exception_ctrl;
  import exception_ctrl_pkg::*;

  localparam int NHW  = 6;
  localparam int SYNC = 2;
  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  hw_int;
  logic        timer_int;
  logic [1:0]  sw_int;
  logic        status_ie;
  logic [7:0]  status_im;
  logic        valid_M, stall_M, in_delayslot_M;
  logic [31:0] pc_M, alu_out_M;
  logic        ri, brk, syscall, overflow, eret, lw_error, sw_error, pc_error;
  logic        epc_we;
  logic [31:0] epc_wdata;
  logic [31:0] exception_type, pc_exception_M, epc, badvaddr;
  logic        flush_exception_M, exl, cause_bd;
  logic [4:0]  cause_exccode;
  logic [7:0]  cause_ip;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  exception_ctrl #(.HW_INT_N(NHW), .SYNC_STAGES(SYNC), .EXC_VECTOR(VEC)) dut (
    .clk(clk), .rst(rst), .hw_int(hw_int), .timer_int(timer_int), .sw_int(sw_int),
    .status_ie(status_ie), .status_im(status_im), .valid_M(valid_M), .stall_M(stall_M),
    .in_delayslot_M(in_delayslot_M), .pc_M(pc_M), .alu_out_M(alu_out_M),
    .ri(ri), .brk(brk), .syscall(syscall), .overflow(overflow), .eret(eret),
    .lw_error(lw_error), .sw_error(sw_error), .pc_error(pc_error),
    .epc_we(epc_we), .epc_wdata(epc_wdata), .exception_type(exception_type),
    .flush_exception_M(flush_exception_M), .pc_exception_M(pc_exception_M),
    .exl(exl), .epc(epc), .cause_bd(cause_bd), .cause_exccode(cause_exccode),
    .cause_ip(cause_ip), .badvaddr(badvaddr)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic        m_exl = 1'b0, m_bd = 1'b0;
  logic [31:0] m_epc = 32'h0, m_badv = 32'h0;
  logic [4:0]  m_code = 5'h0;
  logic [5:0]  hist [SYNC];   // hist[k] = hw_int as sampled k+1 edges ago

  initial for (int k = 0; k < SYNC; k++) hist[k] = '0;

  function automatic logic [7:0] ref_cip();
    logic [5:0] s;
    s = hist[SYNC-1];
    return {s[5] | timer_int, s[4:0], sw_int};
  endfunction

  function automatic logic [31:0] ref_type();
    logic [7:0] ip;
    ip = ref_cip();
    if (status_ie && !m_exl && ((ip & status_im) != 8'h0)) return EXC_TYPE_INT;
    if (lw_error || pc_error) return EXC_TYPE_ADEL;
    if (ri)       return EXC_TYPE_RI;
    if (syscall)  return EXC_TYPE_SYS;
    if (brk)      return EXC_TYPE_BP;
    if (sw_error) return EXC_TYPE_ADES;
    if (overflow) return EXC_TYPE_OV;
    if (eret)     return EXC_TYPE_ERET;
    return EXC_TYPE_NOEXC;
  endfunction

  function automatic logic [4:0] ref_code(input logic [31:0] t);
    case (t)
      EXC_TYPE_ADEL: return 5'h04;
      EXC_TYPE_ADES: return 5'h05;
      EXC_TYPE_SYS:  return 5'h08;
      EXC_TYPE_BP:   return 5'h09;
      EXC_TYPE_RI:   return 5'h0A;
      EXC_TYPE_OV:   return 5'h0C;
      default:       return 5'h00;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  // Model state advance on each clock edge from pre-edge inputs
  initial forever begin
    logic [31:0] t;
    logic        c;
    @(posedge clk);
    t = ref_type();
    c = valid_M && !stall_M && (t != EXC_TYPE_NOEXC);
    if (rst) begin
      m_exl = 0; m_epc = 0; m_bd = 0; m_code = 0; m_badv = 0;
      for (int k = 0; k < SYNC; k++) hist[k] = '0;
    end else begin
      if (c && t != EXC_TYPE_ERET) begin
        if (!m_exl) begin
          m_epc = in_delayslot_M ? pc_M - 32'd4 : pc_M;
          m_bd  = in_delayslot_M;
        end
        m_exl  = 1'b1;
        m_code = ref_code(t);
        if (t == EXC_TYPE_ADEL) m_badv = pc_error ? pc_M : alu_out_M;
        else if (t == EXC_TYPE_ADES) m_badv = alu_out_M;
      end else begin
        if (c) m_exl = 1'b0;
        if (epc_we) m_epc = epc_wdata;
      end
      for (int k = SYNC-1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = hw_int;
    end
  end

  // Every-cycle comparison of all outputs against the model
  initial forever begin
    logic [31:0] t;
    logic        c;
    @(negedge clk);
    if (cmp_en) begin
      t = ref_type();
      c = !rst && valid_M && !stall_M && (t != EXC_TYPE_NOEXC);
      chk("m.exception_type", exception_type, t);
      chk("m.flush", {31'h0, flush_exception_M}, {31'h0, c});
      chk("m.pc_exception", pc_exception_M,
          !c ? 32'h0 : (t == EXC_TYPE_ERET ? m_epc : VEC));
      chk("m.exl", {31'h0, exl}, {31'h0, m_exl});
      chk("m.epc", epc, m_epc);
      chk("m.cause_bd", {31'h0, cause_bd}, {31'h0, m_bd});
      chk("m.exccode", {27'h0, cause_exccode}, {27'h0, m_code});
      chk("m.cause_ip", {24'h0, cause_ip}, {24'h0, ref_cip()});
      chk("m.badvaddr", badvaddr, m_badv);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(); @(posedge clk); #2; endtask
  task automatic look(); @(negedge clk); #1; endtask

  task automatic idle();
    valid_M = 0; stall_M = 0; in_delayslot_M = 0;
    ri = 0; brk = 0; syscall = 0; overflow = 0; eret = 0;
    lw_error = 0; sw_error = 0; pc_error = 0; epc_we = 0;
  endtask

  initial begin
    rst = 1; hw_int = 0; timer_int = 0; sw_int = 0; status_ie = 0; status_im = 0;
    pc_M = 32'h8000_0000; alu_out_M = 0; epc_wdata = 0;
    idle();
    syscall = 1; valid_M = 1;              // must not flush under reset
    tick(); tick(); cmp_en = 1'b1;
    look();
    chk("rst.flush", {31'h0, flush_exception_M}, 32'h0);
    chk("rst.pc_exc", pc_exception_M, 32'h0);
    chk("rst.exl", {31'h0, exl}, 32'h0);
    chk("rst.epc", epc, 32'h0);
    chk("rst.cause_ip", {24'h0, cause_ip}, 32'h0);

    // Interrupt through the synchroniser
    tick(); rst = 0; idle();
    status_ie = 1; status_im = 8'h10; hw_int = 6'b000100; valid_M = 1; pc_M = 32'h8000_0040;
    look(); chk("sync.ip0", {24'h0, cause_ip}, 32'h0);
    tick(); look(); chk("sync.ip1", {24'h0, cause_ip}, 32'h0);
    tick(); look();
    chk("sync.ip2", {24'h0, cause_ip}, 32'h10);
    chk("sync.type", exception_type, EXC_TYPE_INT);
    chk("sync.flush", {31'h0, flush_exception_M}, 32'h1);
    chk("sync.pc", pc_exception_M, 32'hBFC0_0380);
    tick(); look();   // interrupt still pending but EXL masks it
    chk("int.exl", {31'h0, exl}, 32'h1);
    chk("int.code", {27'h0, cause_exccode}, 32'h0);
    chk("int.epc", epc, 32'h8000_0040);
    chk("mask.flush", {31'h0, flush_exception_M}, 32'h0);
    tick(); idle(); hw_int = 0; status_ie = 0;

    // MTC0 EPC then ERET
    tick(); epc_we = 1; epc_wdata = 32'h8000_0200;
    tick(); idle(); eret = 1; valid_M = 1;
    look();
    chk("eret.type", exception_type, EXC_TYPE_ERET);
    chk("eret.pc", pc_exception_M, 32'h8000_0200);
    tick(); idle(); look();
    chk("eret.exl", {31'h0, exl}, 32'h0);

    // Delay-slot syscall
    tick(); syscall = 1; pc_M = 32'h8000_0104; in_delayslot_M = 1; valid_M = 1;
    tick(); idle(); look();
    chk("ds.epc", epc, 32'h8000_0100);
    chk("ds.bd", {31'h0, cause_bd}, 32'h1);
    chk("ds.code", {27'h0, cause_exccode}, 32'h08);

    // Priority and BadVAddr
    tick(); lw_error = 1; ri = 1; overflow = 1; alu_out_M = 32'h1234_5671;
    pc_M = 32'h8000_0500; valid_M = 1;
    look(); chk("pri.type", exception_type, EXC_TYPE_ADEL);
    tick(); idle(); look();
    chk("pri.badv", badvaddr, 32'h1234_5671);
    chk("pri.code", {27'h0, cause_exccode}, 32'h04);
    chk("nest.epc", epc, 32'h8000_0100);
    tick(); pc_error = 1; pc_M = 32'h8000_0002; valid_M = 1;
    tick(); idle(); look();
    chk("pcerr.badv", badvaddr, 32'h8000_0002);

    // Stall hold
    tick(); brk = 1; valid_M = 1; stall_M = 1;
    for (int i = 0; i < 3; i++) begin
      look();
      chk("stall.flush", {31'h0, flush_exception_M}, 32'h0);
      chk("stall.code", {27'h0, cause_exccode}, 32'h04);
      tick();
    end
    stall_M = 0;
    look(); chk("unstall.flush", {31'h0, flush_exception_M}, 32'h1);
    tick(); idle(); look();
    chk("unstall.code", {27'h0, cause_exccode}, 32'h09);
    chk("unstall.flush0", {31'h0, flush_exception_M}, 32'h0);

    // Commit vs MTC0 collisions
    tick(); eret = 1; valid_M = 1;
    tick(); idle(); syscall = 1; valid_M = 1; pc_M = 32'h8000_0300;
    epc_we = 1; epc_wdata = 32'hDEAD_BEEF;
    tick(); idle(); look();
    chk("col.epc", epc, 32'h8000_0300);
    tick(); eret = 1; valid_M = 1; epc_we = 1; epc_wdata = 32'h1111_1110;
    look(); chk("col.eret_pc", pc_exception_M, 32'h8000_0300);
    tick(); idle(); look();
    chk("col.epc_wr", epc, 32'h1111_1110);

    // Reset mid-sequence
    tick(); syscall = 1; valid_M = 1; pc_M = 32'h8000_0400;
    tick(); rst = 1; look();
    chk("rst2.flush", {31'h0, flush_exception_M}, 32'h0);
    chk("rst2.pc", pc_exception_M, 32'h0);
    tick(); rst = 0; idle(); look();
    chk("rst2.exl", {31'h0, exl}, 32'h0);
    chk("rst2.epc", epc, 32'h0);
    chk("rst2.badv", badvaddr, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      tick();
      rst            = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 15) == 0) hw_int = 6'($urandom);
      timer_int      = ($urandom_range(0, 31) == 0);
      sw_int         = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
      status_ie      = ($urandom_range(0, 3) != 0);
      status_im      = 8'($urandom);
      valid_M        = ($urandom_range(0, 3) != 0);
      stall_M        = ($urandom_range(0, 3) == 0);
      in_delayslot_M = $urandom_range(0, 1) == 1;
      pc_M           = $urandom;
      alu_out_M      = $urandom;
      ri             = ($urandom_range(0, 15) == 0);
      brk            = ($urandom_range(0, 15) == 0);
      syscall        = ($urandom_range(0, 15) == 0);
      overflow       = ($urandom_range(0, 15) == 0);
      eret           = ($urandom_range(0, 5) == 0);
      lw_error       = ($urandom_range(0, 15) == 0);
      sw_error       = ($urandom_range(0, 15) == 0);
      pc_error       = ($urandom_range(0, 15) == 0);
      epc_we         = ($urandom_range(0, 7) == 0);
      epc_wdata      = $urandom;
    end
    tick(); idle(); rst = 0;
    look();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
